// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master sequencer: START, address+R/W, one data byte, ACK handling, STOP.
// Drives the SCL generator via i_clock_en/i_clock_stop pulses and SDA as an open-drain enable.
module i2c_master_fsm #(
    parameter int START_HOLD = 4,
    parameter int STOP_SETUP = 4,
    parameter int HCNT_W     = 4
) (
    input  logic       pclk,
    input  logic       prst_n,
    input  logic       cmd_start,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       i_clk,
    input  logic       sda_in,
    output logic       i_clock_en,
    output logic       i_clock_stop,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK,
        S_RDATA, S_MACK, S_STOP_LOW, S_STOP_WAIT, S_DONE
    } state_t;

    localparam logic [HCNT_W-1:0] START_LAST = HCNT_W'(START_HOLD - 1);
    localparam logic [HCNT_W-1:0] STOP_LAST  = HCNT_W'(STOP_SETUP - 1);

    state_t            state_q, state_d;
    logic              i_clk_d_q;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rx_q, rx_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              sda_oe_q, sda_oe_d;
    logic              clock_en_q, clock_en_d;
    logic              clock_stop_q, clock_stop_d;
    logic              ack_err_q, ack_err_d;
    logic [7:0]        rdata_q, rdata_d;

    logic rise, fall, accept, hold_done, setup_done;

    assign rise       = i_clk & ~i_clk_d_q;
    assign fall       = ~i_clk & i_clk_d_q;
    // busy is already low during DONE, so a command arriving then is taken as well
    assign accept     = cmd_start & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign hold_done  = (hcnt_q == START_LAST);
    assign setup_done = (hcnt_q == STOP_LAST);

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q      <= S_IDLE;
            i_clk_d_q    <= 1'b1;
            shift_q      <= 8'h00;
            rw_q         <= 1'b0;
            wdata_q      <= 8'h00;
            rx_q         <= 8'h00;
            bitcnt_q     <= 3'd7;
            hcnt_q       <= '0;
            sda_oe_q     <= 1'b0;
            clock_en_q   <= 1'b0;
            clock_stop_q <= 1'b0;
            ack_err_q    <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            i_clk_d_q    <= i_clk;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            rx_q         <= rx_d;
            bitcnt_q     <= bitcnt_d;
            hcnt_q       <= hcnt_d;
            sda_oe_q     <= sda_oe_d;
            clock_en_q   <= clock_en_d;
            clock_stop_q <= clock_stop_d;
            ack_err_q    <= ack_err_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: state_d = accept ? S_START : S_IDLE;
            S_START:        if (hold_done) state_d = S_ADDR;
            S_ADDR:         if (rise && bitcnt_q == 3'd0) state_d = S_ADDR_ACK;
            S_ADDR_ACK: begin
                if (rise) begin
                    if (sda_in)    state_d = S_STOP_LOW;
                    else if (rw_q) state_d = S_RDATA;
                    else           state_d = S_WDATA;
                end
            end
            S_WDATA:        if (rise && bitcnt_q == 3'd0) state_d = S_WACK;
            S_WACK:         if (rise) state_d = S_STOP_LOW;
            S_RDATA:        if (rise && bitcnt_q == 3'd0) state_d = S_MACK;
            S_MACK:         if (rise) state_d = S_STOP_LOW;
            S_STOP_LOW:     if (rise) state_d = S_STOP_WAIT;
            S_STOP_WAIT:    if (setup_done) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        rx_d         = rx_q;
        bitcnt_d     = bitcnt_q;
        hcnt_d       = hcnt_q;
        sda_oe_d     = sda_oe_q;
        clock_en_d   = 1'b0;
        clock_stop_d = 1'b0;
        ack_err_d    = ack_err_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            S_START: begin
                hcnt_d = hcnt_q + HCNT_W'(1);
                if (hold_done) begin
                    clock_en_d = 1'b1;
                    bitcnt_d   = 3'd7;
                end
            end
            S_ADDR, S_WDATA: begin
                // SDA only changes while SCL is low; open-drain enable is the inverted bit
                if (fall) sda_oe_d = (state_q == S_ADDR) ? ~shift_q[bitcnt_q] : ~wdata_q[bitcnt_q];
                if (rise) bitcnt_d = bitcnt_q - 3'd1;
            end
            S_ADDR_ACK, S_WACK: begin
                if (fall) sda_oe_d = 1'b0;
                if (rise) begin
                    if (sda_in) ack_err_d = 1'b1;
                    bitcnt_d = 3'd7;
                end
            end
            S_RDATA: begin
                if (fall) sda_oe_d = 1'b0;
                if (rise) begin
                    rx_d[bitcnt_q] = sda_in;
                    bitcnt_d       = bitcnt_q - 3'd1;
                end
            end
            S_MACK: begin
                if (fall) sda_oe_d = 1'b0;
            end
            S_STOP_LOW: begin
                if (fall) sda_oe_d = 1'b1;
                if (rise) begin
                    clock_stop_d = 1'b1;
                    hcnt_d       = '0;
                end
            end
            S_STOP_WAIT: begin
                hcnt_d = hcnt_q + HCNT_W'(1);
                if (setup_done) begin
                    sda_oe_d = 1'b0;
                    // a read only reaches here with ack_err set if the address was NACKed
                    if (rw_q && !ack_err_q) rdata_d = rx_q;
                end
            end
            default: ;
        endcase

        if (accept) begin
            shift_d   = {cmd_addr, cmd_rw};
            rw_d      = cmd_rw;
            wdata_d   = cmd_wdata;
            ack_err_d = 1'b0;
            sda_oe_d  = 1'b1;
            hcnt_d    = '0;
        end
    end

    always_comb begin
        busy         = (state_q != S_IDLE) && (state_q != S_DONE);
        done         = (state_q == S_DONE);
        i_clock_en   = clock_en_q;
        i_clock_stop = clock_stop_q;
        sda_oe       = sda_oe_q;
        ack_err      = ack_err_q;
        rdata        = rdata_q;
    end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm: SCL generator model, bit-level slave model, transaction-level reference.
module tb_i2c_master_fsm;

    localparam int SH = 4;
    localparam int SS = 4;
    localparam int H  = 8;

    logic       pclk = 1'b0;
    logic       prst_n;
    logic       cmd_start, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       scl;
    logic       sda_in, sda_line;
    logic       i_clock_en, i_clock_stop, sda_oe, busy, done, ack_err;
    logic [7:0] rdata;

    i2c_master_fsm #(.START_HOLD(SH), .STOP_SETUP(SS), .HCNT_W(4)) dut (
        .pclk(pclk), .prst_n(prst_n), .cmd_start(cmd_start), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .i_clk(scl), .sda_in(sda_in),
        .i_clock_en(i_clock_en), .i_clock_stop(i_clock_stop), .sda_oe(sda_oe),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
    );

    always #5 pclk = ~pclk;

    // Clock generator: starts toggling (low first) after en falls, freezes high after stop falls.
    logic gen_run, en_prev, stop_prev;
    int   gen_cnt;
    always @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            scl <= 1'b1; gen_run <= 1'b0; gen_cnt <= 0; en_prev <= 1'b0; stop_prev <= 1'b0;
        end else begin
            en_prev   <= i_clock_en;
            stop_prev <= i_clock_stop;
            if (en_prev && !i_clock_en) begin
                gen_run <= 1'b1; gen_cnt <= 0;
            end else if (stop_prev && !i_clock_stop) begin
                gen_run <= 1'b0; scl <= 1'b1;
            end else if (gen_run) begin
                if (gen_cnt == H - 1) begin scl <= ~scl; gen_cnt <= 0; end
                else gen_cnt <= gen_cnt + 1;
            end
        end
    end

    // Slave and bus monitor
    logic        slave_pull, scl_prev, sda_prev, rw_seen;
    logic        cfg_ack_a, cfg_ack_d;
    logic [7:0]  cfg_rd;
    logic [31:0] obs_bits = 0;
    int          obs_n = 0, start_cnt = 0, stop_cnt = 0;

    assign sda_line = ~(sda_oe | slave_pull);
    assign sda_in   = sda_line;

    function automatic logic pull_for(input int nx);
        if (nx == 9) return cfg_ack_a;
        if (cfg_ack_a && !rw_seen && nx == 18) return cfg_ack_d;
        if (cfg_ack_a && rw_seen && nx >= 10 && nx <= 17) return ~cfg_rd[17 - nx];
        return 1'b0;
    endfunction

    always @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            scl_prev <= 1'b1; sda_prev <= 1'b1; slave_pull <= 1'b0; rw_seen <= 1'b0;
        end else begin
            scl_prev <= scl;
            sda_prev <= sda_line;
            if (scl && scl_prev && sda_prev && !sda_line) begin
                obs_n <= 0; obs_bits <= 0; start_cnt <= start_cnt + 1;
            end else if (scl && scl_prev && !sda_prev && sda_line) begin
                stop_cnt <= stop_cnt + 1;
            end
            if (scl && !scl_prev) begin
                obs_bits <= {obs_bits[30:0], sda_line};
                obs_n    <= obs_n + 1;
                if (obs_n == 7) rw_seen <= sda_line;
            end
            if (!scl && scl_prev) slave_pull <= pull_for(obs_n + 1);
        end
    end

    int         done_cnt = 0;
    logic [7:0] rdata_at_done;
    logic       err_at_done, busy_at_done;
    always @(negedge pclk) begin
        if (done) begin
            done_cnt      <= done_cnt + 1;
            rdata_at_done <= rdata;
            err_at_done   <= ack_err;
            busy_at_done  <= busy;
        end
    end

    int n_vec = 0, n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Reference: the SDA value expected at every SCL rise of one transaction, from protocol rules.
    logic [7:0] model_rdata;
    function automatic void model_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                      input logic aa, input logic ad, input logic [7:0] rd,
                                      output logic [31:0] bits, output int n,
                                      output logic err, output logic [7:0] rdo);
        bit         q[$];
        logic [7:0] first, data;
        first = {a, rw};
        for (int i = 7; i >= 0; i--) q.push_back(first[i]);
        q.push_back(!aa);
        if (aa) begin
            data = rw ? rd : wd;
            for (int i = 7; i >= 0; i--) q.push_back(data[i]);
            q.push_back(rw ? 1'b1 : !ad);
        end
        q.push_back(1'b0);
        bits = 0;
        foreach (q[i]) bits = {bits[30:0], q[i]};
        n   = q.size();
        err = !aa || (!rw && !ad);
        rdo = (rw && aa) ? rd : model_rdata;
    endfunction

    int done0, start0, stop0;

    task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          input logic aa, input logic ad, input logic [7:0] rd);
        int   lat;
        logic hold_ok;
        cfg_ack_a = aa; cfg_ack_d = ad; cfg_rd = rd;
        done0 = done_cnt; start0 = start_cnt; stop0 = stop_cnt;
        @(negedge pclk);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_start = 1'b1;
        lat = 0; hold_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            cmd_start = 1'b0;
            lat++;
            if (i_clock_en) break;
            if (!sda_oe || !scl || !busy) hold_ok = 1'b0;
        end
        // scramble the command bus to show the fields were captured
        cmd_addr = 7'($urandom); cmd_rw = 1'($urandom); cmd_wdata = 8'($urandom);
        chk("start_latency", lat, SH + 1);
        chk("start_hold", {31'd0, hold_ok}, 1);
    endtask

    task automatic finish_txn(input string nm, input logic [31:0] eb, input int en,
                              input logic eerr, input logic [7:0] erd);
        logic got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge pclk);
            if (done_cnt != done0) begin got = 1'b1; break; end
        end
        chk({nm, "_done_seen"}, {31'd0, got}, 1);
        repeat (40) @(posedge pclk);
        @(negedge pclk);
        chk({nm, "_done_count"}, done_cnt - done0, 1);
        chk({nm, "_rises"}, obs_n, en);
        chk({nm, "_sda_bits"}, obs_bits, eb);
        chk({nm, "_ack_err"}, {31'd0, err_at_done}, {31'd0, eerr});
        chk({nm, "_rdata"}, {24'd0, rdata_at_done}, {24'd0, erd});
        chk({nm, "_busy_at_done"}, {31'd0, busy_at_done}, 0);
        chk({nm, "_start_cond"}, start_cnt - start0, 1);
        chk({nm, "_stop_cond"}, stop_cnt - stop0, 1);
        chk({nm, "_idle"}, {29'd0, sda_oe, busy, scl}, 3'b001);
        $display("txn %s: rises=%0d bits=%0h ack_err=%0b rdata=%02h", nm, obs_n, obs_bits,
                 err_at_done, rdata_at_done);
        model_rdata = erd;
    endtask

    typedef struct {
        logic [6:0] addr; logic rw; logic [7:0] wdata;
        logic ack_a; logic ack_d; logic [7:0] rd;
        logic exp_err; logic [7:0] exp_rdata; int exp_n;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [31:0] eb;
        int          en;
        logic        eerr;
        logic [7:0]  erd;
        logic        reached;

        vt[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 19};
        vt[1] = '{7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h5A, 19};
        vt[2] = '{7'h11, 1'b1, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 8'h5A, 10};
        vt[3] = '{7'h2A, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 19};
        vt[4] = '{7'h7F, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 19};
        vt[5] = '{7'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 19};
        vt[6] = '{7'h01, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 19};

        prst_n = 1'b0; cmd_start = 1'b0; cmd_rw = 1'b0; cmd_addr = 0; cmd_wdata = 0;
        cfg_ack_a = 1'b1; cfg_ack_d = 1'b1; cfg_rd = 0; model_rdata = 8'h00;
        repeat (3) @(negedge pclk);
        chk("reset_outputs", {26'd0, i_clock_en, i_clock_stop, sda_oe, busy, done, ack_err}, 0);
        chk("reset_rdata", {24'd0, rdata}, 0);
        prst_n = 1'b1;
        repeat (3) @(negedge pclk);
        chk("idle_after_reset", {28'd0, busy, done, sda_oe, scl}, 4'b0001);

        foreach (vt[i]) begin
            model_txn(vt[i].addr, vt[i].rw, vt[i].wdata, vt[i].ack_a, vt[i].ack_d, vt[i].rd,
                      eb, en, eerr, erd);
            launch(vt[i].addr, vt[i].rw, vt[i].wdata, vt[i].ack_a, vt[i].ack_d, vt[i].rd);
            finish_txn($sformatf("vec%0d", i), eb, vt[i].exp_n, vt[i].exp_err, vt[i].exp_rdata);
        end

        // cmd_start while busy must be ignored
        model_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, eb, en, eerr, erd);
        launch(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00);
        repeat (60) @(posedge pclk);
        @(negedge pclk);
        cmd_addr = 7'h7F; cmd_rw = 1'b1; cmd_wdata = 8'h00; cmd_start = 1'b1;
        @(negedge pclk);
        cmd_start = 1'b0;
        finish_txn("repulse", eb, en, eerr, erd);

        // reset while the master drives data bit 3 (a 0, so SDA is pulled low)
        launch(7'h2B, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00);
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge pclk);
            if (obs_n == 13 && !scl) begin reached = 1'b1; break; end
        end
        chk("reach_wdata_bit3", {31'd0, reached}, 1);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("pre_reset_sda_oe", {31'd0, sda_oe}, 1);
        prst_n = 1'b0;
        #1;
        chk("midrst_outputs", {27'd0, sda_oe, busy, i_clock_en, i_clock_stop, done}, 0);
        repeat (3) @(negedge pclk);
        prst_n = 1'b1;
        model_rdata = 8'h00;
        $display("txn midreset: sda_oe=%0b busy=%0b", sda_oe, busy);
        model_txn(7'h66, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81, eb, en, eerr, erd);
        launch(7'h66, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81);
        finish_txn("after_reset", eb, en, eerr, erd);

        for (int k = 0; k < 16; k++) begin
            logic [6:0] a; logic rw, aa, ad; logic [7:0] wd, rd;
            a  = 7'($urandom); rw = 1'($urandom); wd = 8'($urandom); rd = 8'($urandom);
            aa = ($urandom_range(0, 7) != 0);
            ad = ($urandom_range(0, 3) != 0);
            model_txn(a, rw, wd, aa, ad, rd, eb, en, eerr, erd);
            launch(a, rw, wd, aa, ad, rd);
            finish_txn($sformatf("rand%0d", k), eb, en, eerr, erd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
